cmd_uart_wrapper: RTL and testbench

//  Knight-side end of the RemoteComm serial link. Receives 16-bit commands as two UART

---
 rtl/knight_pkg.sv | 39 +++
 rtl/uart_core.sv | 209 ++++++++++++++++++++
 rtl/cmd_uart_wrapper.sv | 129 ++++++++++++
 tb/tb_cmd_uart_wrapper.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knight_pkg.sv
`default_nettype none
// ============================================================================
// Module   : knight_pkg
// Purpose  : Shared types and constants for the Knight-side RemoteComm link.
//            Holds the RX/TX/assembly state encodings, the positive-ack
//            response byte and the default link timing.
// Revision : 1.0 - initial release
// ============================================================================
package knight_pkg;

    // Response byte the command processor returns on success
    localparam logic [7:0] POS_ACK = 8'hA5;

    // 50 MHz system clock, 19200 baud
    localparam int unsigned DEF_BAUD_DIV     = 2604;
    // Longest allowed gap between the two stop samples of one command
    localparam int unsigned DEF_BYTE_TIMEOUT = 2000000;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic {
        ASM_WAIT_HI = 1'b0,
        ASM_WAIT_LO = 1'b1
    } asm_state_t;

endpackage : knight_pkg
`default_nettype wire

// File: rtl/uart_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_core
// Purpose  : Full-duplex 8N1 byte UART. RX and TX run independently.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            i_rx            - serial input, asynchronous, idle high
//            o_tx            - serial output, idle high
//            i_tx_data       - byte to send, captured with i_tx_start
//            i_tx_start      - request; ignored while o_tx_busy
//            o_tx_busy       - transmitter active
//            o_tx_done       - high on the last clock of the stop bit
//            o_rx_data       - last received byte
//            o_byte_vld      - one-cycle pulse, byte received with good stop
//            o_frame_err     - one-cycle pulse, byte received with bad stop
// Notes    : BAUD_DIV must be >= 16 and fit the 12-bit baud counters.
// Revision : 1.0 - initial release
// ============================================================================
module uart_core
    import knight_pkg::*;
#(
    parameter int unsigned BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic       o_tx,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_start,
    output logic       o_tx_busy,
    output logic       o_tx_done,
    output logic [7:0] o_rx_data,
    output logic       o_byte_vld,
    output logic       o_frame_err
);

    // Counters are loaded with N-1 and count down to zero, so an event
    // fires exactly N clocks after the load.
    localparam logic [11:0] c_bit_last  = 12'(BAUD_DIV - 1);
    localparam logic [11:0] c_half_last = 12'(BAUD_DIV / 2 - 1);

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic        r_rx_s1, r_rx_s2, r_rx_s3;
    rx_state_t   r_rx_state, w_rx_next;
    logic [11:0] r_rx_baud;
    logic [3:0]  r_rx_bits;
    logic [7:0]  r_rx_shift;
    logic        r_byte_vld, r_frame_err;
    logic        w_rx_tick, w_rx_fall;

    // s1/s2 form the synchronizer; s3 is history for edge detection only.
    // All reset high so a reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= i_rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rx_state <= RX_IDLE;
        else     r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_tick = (r_rx_baud == 12'd0);
        w_rx_fall = r_rx_s3 & ~r_rx_s2;
        case (r_rx_state)
            RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
            // Mid-start re-sample: a high line means the edge was a glitch
            RX_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_tick && (r_rx_bits == 4'd7)) w_rx_next = RX_STOP;
            RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_baud   <= 12'd0;
            r_rx_bits   <= 4'd0;
            r_rx_shift  <= 8'd0;
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    // Preloaded so the start re-sample lands mid-bit
                    r_rx_baud <= c_half_last;
                    r_rx_bits <= 4'd0;
                end
                RX_START: begin
                    if (w_rx_tick) r_rx_baud <= c_bit_last;
                    else           r_rx_baud <= r_rx_baud - 12'd1;
                end
                RX_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_baud  <= c_bit_last;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        r_rx_bits  <= r_rx_bits + 4'd1;
                    end else begin
                        r_rx_baud  <= r_rx_baud - 12'd1;
                    end
                end
                RX_STOP: begin
                    if (w_rx_tick) begin
                        r_byte_vld  <= r_rx_s2;
                        r_frame_err <= ~r_rx_s2;
                    end else begin
                        r_rx_baud   <= r_rx_baud - 12'd1;
                    end
                end
                default: r_rx_baud <= c_half_last;
            endcase
        end
    end

    assign o_rx_data   = r_rx_shift;
    assign o_byte_vld  = r_byte_vld;
    assign o_frame_err = r_frame_err;

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    tx_state_t   r_tx_state, w_tx_next;
    logic [11:0] r_tx_baud;
    logic [3:0]  r_tx_bits;
    logic [7:0]  r_tx_shift;
    logic        r_tx;
    logic        w_tx_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tx_state <= TX_IDLE;
        else     r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_tick = (r_tx_baud == 12'd0);
        o_tx_busy = (r_tx_state != TX_IDLE);
        o_tx_done = (r_tx_state == TX_STOP) && w_tx_tick;
        case (r_tx_state)
            TX_IDLE:  if (i_tx_start) w_tx_next = TX_START;
            TX_START: if (w_tx_tick) w_tx_next = TX_DATA;
            TX_DATA:  if (w_tx_tick && (r_tx_bits == 4'd7)) w_tx_next = TX_STOP;
            TX_STOP:  if (w_tx_tick) w_tx_next = TX_IDLE;
            default:  w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx       <= 1'b1;
            r_tx_baud  <= 12'd0;
            r_tx_bits  <= 4'd0;
            r_tx_shift <= 8'd0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx <= 1'b1;
                    if (i_tx_start) begin
                        r_tx_shift <= i_tx_data;
                        r_tx       <= 1'b0;
                        r_tx_baud  <= c_bit_last;
                        r_tx_bits  <= 4'd0;
                    end
                end
                TX_START: begin
                    if (w_tx_tick) begin
                        r_tx      <= r_tx_shift[0];
                        r_tx_baud <= c_bit_last;
                    end else begin
                        r_tx_baud <= r_tx_baud - 12'd1;
                    end
                end
                TX_DATA: begin
                    if (w_tx_tick) begin
                        // Ones shift in from the top, so after the 8th bit
                        // the next value presented is the stop bit.
                        r_tx_shift <= {1'b1, r_tx_shift[7:1]};
                        r_tx       <= r_tx_shift[1];
                        r_tx_bits  <= r_tx_bits + 4'd1;
                        r_tx_baud  <= c_bit_last;
                    end else begin
                        r_tx_baud  <= r_tx_baud - 12'd1;
                    end
                end
                TX_STOP: begin
                    r_tx <= 1'b1;
                    if (!w_tx_tick) r_tx_baud <= r_tx_baud - 12'd1;
                end
                default: r_tx <= 1'b1;
            endcase
        end
    end

    assign o_tx = r_tx;

endmodule : uart_core
`default_nettype wire

// File: rtl/cmd_uart_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : cmd_uart_wrapper
// Purpose  : Knight-side end of the RemoteComm link. Assembles 16-bit
//            commands from two received bytes (high byte first) and
//            serializes 8-bit responses back to the remote.
// Ports    : clk, rst     - clock, asynchronous active-high reset
//            RX / TX      - serial lines, idle high
//            cmd          - assembled command {hi, lo}
//            cmd_rdy      - command valid, held until clr_cmd_rdy
//            clr_cmd_rdy  - consumer acknowledge
//            resp         - response byte, sampled with send_resp
//            send_resp    - one-cycle transmit request
//            tx_busy      - transmitter active
//            resp_sent    - pulse on the last clock of the stop bit
//            frame_err    - pulse on a received byte with a bad stop bit
// Revision : 1.0 - initial release
// ============================================================================
module cmd_uart_wrapper
    import knight_pkg::*;
#(
    parameter int unsigned BAUD_DIV     = DEF_BAUD_DIV,
    parameter int unsigned BYTE_TIMEOUT = DEF_BYTE_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        tx_busy,
    output logic        resp_sent,
    output logic        frame_err
);

    localparam logic [20:0] c_to_limit = 21'(BYTE_TIMEOUT);

    logic [7:0] w_rx_data;
    logic       w_byte_vld;
    logic       w_frame_err;

    uart_core #(
        .BAUD_DIV    (BAUD_DIV)
    ) u_uart (
        .clk         (clk),
        .rst         (rst),
        .i_rx        (RX),
        .o_tx        (TX),
        .i_tx_data   (resp),
        .i_tx_start  (send_resp),
        .o_tx_busy   (tx_busy),
        .o_tx_done   (resp_sent),
        .o_rx_data   (w_rx_data),
        .o_byte_vld  (w_byte_vld),
        .o_frame_err (w_frame_err)
    );

    assign frame_err = w_frame_err;

    // ------------------------------------------------------------------
    // Command assembly
    // ------------------------------------------------------------------
    asm_state_t  r_asm_state, w_asm_next;
    logic        w_latch_hi, w_cmd_set, w_timeout;
    logic [7:0]  r_hi_byte;
    logic [20:0] r_to_cnt;
    logic [15:0] r_cmd;
    logic        r_cmd_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_asm_state <= ASM_WAIT_HI;
        else     r_asm_state <= w_asm_next;
    end

    always_comb begin
        w_asm_next = r_asm_state;
        w_latch_hi = 1'b0;
        w_cmd_set  = 1'b0;
        w_timeout  = (r_to_cnt == c_to_limit);
        case (r_asm_state)
            ASM_WAIT_HI: begin
                if (w_byte_vld) begin
                    w_latch_hi = 1'b1;
                    w_asm_next = ASM_WAIT_LO;
                end
            end
            ASM_WAIT_LO: begin
                if (w_byte_vld) begin
                    w_cmd_set  = 1'b1;
                    w_asm_next = ASM_WAIT_HI;
                end else if (w_frame_err || w_timeout) begin
                    // Resync: the stored high byte is simply abandoned
                    w_asm_next = ASM_WAIT_HI;
                end
            end
            default: w_asm_next = ASM_WAIT_HI;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi_byte <= 8'd0;
            r_to_cnt  <= 21'd0;
            r_cmd     <= 16'd0;
            r_cmd_rdy <= 1'b0;
        end else begin
            if (w_latch_hi) begin
                r_hi_byte <= w_rx_data;
                r_to_cnt  <= 21'd0;
            end else if ((r_asm_state == ASM_WAIT_LO) && !w_timeout) begin
                r_to_cnt  <= r_to_cnt + 21'd1;
            end

            if (w_cmd_set) r_cmd <= {r_hi_byte, w_rx_data};

            // A new command wins over a same-cycle acknowledge
            if (w_cmd_set)                      r_cmd_rdy <= 1'b1;
            else if (w_latch_hi || clr_cmd_rdy) r_cmd_rdy <= 1'b0;
        end
    end

    assign cmd     = r_cmd;
    assign cmd_rdy = r_cmd_rdy;

endmodule : cmd_uart_wrapper
`default_nettype wire

// File: tb/tb_cmd_uart_wrapper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cmd_uart_wrapper
// Purpose  : Self-checking bench for cmd_uart_wrapper. Drives 8N1 frames
//            on RX, decodes TX, and compares against expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_uart_wrapper;

    localparam int B  = 16;
    localparam int TO = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        tx_busy;
    logic        resp_sent;
    logic        frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int frame_err_cnt = 0;
    int rdy_rise_cnt  = 0;
    logic rdy_prev = 1'b0;

    always #5 clk = ~clk;

    cmd_uart_wrapper #(
        .BAUD_DIV     (B),
        .BYTE_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .tx_busy     (tx_busy),
        .resp_sent   (resp_sent),
        .frame_err   (frame_err)
    );

    always @(negedge clk) begin
        if (frame_err) frame_err_cnt <= frame_err_cnt + 1;
        if (cmd_rdy && !rdy_prev) rdy_rise_cnt <= rdy_rise_cnt + 1;
        rdy_prev <= cmd_rdy;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame on RX, starting and ending on a falling clock edge.
    // rdy_at = negedge index (from the start bit) where cmd_rdy is first seen.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok, output int rdy_at);
        logic [9:0] frame;
        frame  = {stop_ok, b, 1'b0};
        rdy_at = -1;
        for (int n = 0; n < 10 * B; n++) begin
            if (n % B == 0) RX = frame[n / B];
            @(negedge clk);
            if (cmd_rdy && rdy_at < 0) rdy_at = n + 1;
        end
        RX = 1'b1;
        if (!stop_ok) tick(B);
    endtask

    task automatic send_cmd(input logic [7:0] hi, input logic [7:0] lo);
        int d;
        send_byte(hi, 1'b1, d);
        send_byte(lo, 1'b1, d);
        tick(2);
    endtask

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        tick(1);
    endtask

    // Issues one response and decodes the TX frame by sampling mid-bit.
    // Returns on the negedge where resp_sent is expected.
    task automatic tx_frame(input logic [7:0] r, input logic mid_req);
        logic [9:0] bits;
        int sent_at;
        int sent_n;
        bits    = '1;
        sent_at = -1;
        sent_n  = 0;
        resp      = r;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        check("tx_busy_after_req", {31'd0, tx_busy}, 32'd1);
        for (int n = 0; n < 10 * B; n++) begin
            if (n > 0) @(negedge clk);
            if (n % B == B / 2) bits[n / B] = TX;
            if (resp_sent) begin
                sent_n++;
                if (sent_at < 0) sent_at = n;
            end
            if (mid_req && n == 5 * B) begin
                resp      = ~r;
                send_resp = 1'b1;
            end else begin
                send_resp = 1'b0;
            end
        end
        resp = r;
        check("tx_start_bit", {31'd0, bits[0]}, 32'd0);
        check("tx_stop_bit", {31'd0, bits[9]}, 32'd1);
        check("tx_data", {24'd0, bits[8:1]}, {24'd0, r});
        check("resp_sent_time", sent_at, 10 * B - 1);
        check("resp_sent_count", sent_n, 1);
    endtask

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] exp_cmd;
    } vec_t;

    initial begin : main
        vec_t        vecs[5];
        int          rdy_at;
        int          base;
        int          d;
        logic        have_hi;
        logic [7:0]  hi_m;
        logic [15:0] exp_cmd;
        logic        exp_rdy;
        int          exp_ferr;
        logic [7:0]  bv[4];
        logic        bg[4];
        int          nb;
        logic [7:0]  rr;

        vecs[0] = '{8'h47, 8'hF3, 16'h47F3};
        vecs[1] = '{8'h00, 8'h00, 16'h0000};
        vecs[2] = '{8'hFF, 8'hFF, 16'hFFFF};
        vecs[3] = '{8'h80, 8'h01, 16'h8001};
        vecs[4] = '{8'hA5, 8'h5A, 16'hA55A};

        rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0; resp = 8'h00; send_resp = 1'b0;
        tick(3);
        check("reset_TX", {31'd0, TX}, 32'd1);
        check("reset_cmd", {16'd0, cmd}, 32'd0);
        check("reset_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("reset_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("reset_resp_sent", {31'd0, resp_sent}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        tick(4);

        // Table: plain commands, ready timing on the low byte, acknowledge
        for (int i = 0; i < 5; i++) begin
            send_byte(vecs[i].hi, 1'b1, rdy_at);
            check("rdy_after_hi", {31'd0, cmd_rdy}, 32'd0);
            send_byte(vecs[i].lo, 1'b1, rdy_at);
            check("rdy_window", {31'd0, (rdy_at >= 9 * B + B / 2) && (rdy_at <= 9 * B + B / 2 + 6)}, 32'd1);
            check("tbl_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
            check("tbl_cmd", {16'd0, cmd}, {16'd0, vecs[i].exp_cmd});
            pulse_clr();
            check("tbl_clr_rdy", {31'd0, cmd_rdy}, 32'd0);
            check("tbl_cmd_hold", {16'd0, cmd}, {16'd0, vecs[i].exp_cmd});
        end

        // Set and clear in the same cycle: set must win
        send_byte(8'h11, 1'b1, d);
        clr_cmd_rdy = 1'b1;
        send_byte(8'h22, 1'b1, rdy_at);
        clr_cmd_rdy = 1'b0;
        tick(1);
        check("set_wins_pulse_seen", {31'd0, rdy_at >= 0}, 32'd1);
        check("set_wins_cmd", {16'd0, cmd}, 32'h1122);
        check("set_wins_cleared", {31'd0, cmd_rdy}, 32'd0);

        // Response, with an ignored mid-frame request, then back-to-back
        tx_frame(8'hA5, 1'b1);
        tick(1);
        check("tx_idle_busy", {31'd0, tx_busy}, 32'd0);
        check("tx_idle_line", {31'd0, TX}, 32'd1);
        tx_frame(8'h5A, 1'b0);
        tick(1);
        tx_frame(8'h3C, 1'b0);
        tick(2);

        // Timeout resync
        base = rdy_rise_cnt;
        send_byte(8'h47, 1'b1, d);
        tick(TO + 10);
        send_cmd(8'h20, 8'h01);
        check("timeout_cmd", {16'd0, cmd}, 32'h2001);
        check("timeout_rdy_once", rdy_rise_cnt - base, 1);
        pulse_clr();

        // Bad stop in WAIT_HI: no advance
        base = frame_err_cnt;
        send_byte(8'h47, 1'b0, d);
        tick(2);
        check("ferr_hi_count", frame_err_cnt - base, 1);
        check("ferr_hi_rdy", {31'd0, cmd_rdy}, 32'd0);
        send_cmd(8'h12, 8'h34);
        check("ferr_hi_cmd", {16'd0, cmd}, 32'h1234);
        pulse_clr();

        // Bad stop in WAIT_LO: resync
        base = frame_err_cnt;
        send_byte(8'h55, 1'b1, d);
        send_byte(8'h66, 1'b0, d);
        send_cmd(8'h9A, 8'hBC);
        check("ferr_lo_count", frame_err_cnt - base, 1);
        check("ferr_lo_cmd", {16'd0, cmd}, 32'h9ABC);
        pulse_clr();

        // Start-bit glitch
        base = frame_err_cnt;
        RX = 1'b0;
        tick(B / 4);
        RX = 1'b1;
        tick(2 * B);
        check("glitch_no_ferr", frame_err_cnt - base, 0);
        check("glitch_no_rdy", {31'd0, cmd_rdy}, 32'd0);
        send_cmd(8'h66, 8'h77);
        check("glitch_cmd", {16'd0, cmd}, 32'h6677);

        // Reset during RX data bit 4 and TX data bit 3 (cmd_rdy left set)
        check("pre_rst_rdy", {31'd0, cmd_rdy}, 32'd1);
        resp = 8'hA5;
        for (int n = 0; n < 5 * B + B / 2; n++) begin
            if (n % B == 0) RX = (n == 0) ? 1'b0 : ((8'hC3 >> (n / B - 1)) & 8'h01) != 8'h00;
            send_resp = (n == B);
            @(negedge clk);
        end
        send_resp = 1'b0;
        check("pre_rst_busy", {31'd0, tx_busy}, 32'd1);
        check("pre_rst_tx_low", {31'd0, TX}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_TX", {31'd0, TX}, 32'd1);
        check("mid_rst_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("mid_rst_cmd", {16'd0, cmd}, 32'd0);
        check("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
        @(negedge clk);
        RX = 1'b1;
        rst = 1'b0;
        tick(2 * B);
        send_cmd(8'hBE, 8'hEF);
        check("post_rst_cmd", {16'd0, cmd}, 32'hBEEF);
        check("post_rst_rdy", {31'd0, cmd_rdy}, 32'd1);
        pulse_clr();

        // Randomized traffic against a byte-pairing model
        have_hi  = 1'b0;
        hi_m     = 8'h00;
        exp_cmd  = 16'hBEEF;
        exp_rdy  = 1'b0;
        exp_ferr = frame_err_cnt;
        for (int it = 0; it < 16; it++) begin
            nb = $urandom_range(1, 4);
            for (int j = 0; j < nb; j++) begin
                bv[j] = 8'($urandom);
                bg[j] = ($urandom_range(0, 5) != 0);
                if (!bg[j]) begin
                    exp_ferr++;
                    have_hi = 1'b0;
                end else if (!have_hi) begin
                    hi_m    = bv[j];
                    have_hi = 1'b1;
                    exp_rdy = 1'b0;
                end else begin
                    exp_cmd = {hi_m, bv[j]};
                    exp_rdy = 1'b1;
                    have_hi = 1'b0;
                end
            end
            if (it % 4 == 0) begin
                rr = 8'($urandom);
                fork
                    begin
                        int dd;
                        for (int j = 0; j < nb; j++) send_byte(bv[j], bg[j], dd);
                    end
                    tx_frame(rr, 1'b0);
                join
            end else begin
                for (int j = 0; j < nb; j++) send_byte(bv[j], bg[j], d);
            end
            tick(2);
            check("rand_rdy", {31'd0, cmd_rdy}, {31'd0, exp_rdy});
            check("rand_cmd", {16'd0, cmd}, {16'd0, exp_cmd});
            check("rand_ferr", frame_err_cnt, exp_ferr);
            pulse_clr();
            exp_rdy = 1'b0;
            if (have_hi && ($urandom_range(0, 1) == 1)) begin
                tick(TO + 10);
                have_hi = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cmd_uart_wrapper
`default_nettype wire
